velocity_prcs_sched: RTL
========================

# velocity_prcs_sched

- Arbitrates paddle-hit requests from player A and player B onto the single shared `velocity_prcs` datapath.
- Sequences each transaction: latch the winner's speed and angle, hold them stable for the datapath's fixed latency, capture the 32-bit {vx, vy} result, and hand it to ball physics over a valid/ready handshake.
- Sits between the two paddle hit detectors and the ball motion update logic.

## Interface
Parameters:
- LATENCY, 4, number of cycles `velocity_prcs` needs with stable inputs before its output is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_a_valid  in  1  player A hit request.
- req_a_ready  out  1  player A request accepted this cycle.
- req_a_velocity  in  16  player A ball speed, sign-magnitude, 1.11.4.
- req_a_angle  in  16  player A ball angle, same encoding used by `velocity_prcs`.
- req_b_valid / req_b_ready / req_b_velocity / req_b_angle: same as the player A ports, for player B.
- vp_velocity  out  16  drives `velocity_prcs.ball_velocity`.
- vp_angle  out  16  drives `velocity_prcs.ball_angle`.
- vp_result  in  32  from `velocity_prcs.ball_velocity_modified`; [31:16] is vx, [15:0] is vy.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_vx  out  16  captured vx.
- out_vy  out  16  captured vy, after optional mirroring.
- out_player  out  1  source of the result: 0 = A, 1 = B.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, HOLD.
- **IDLE**
  - Grant logic is combinational. If only one request is valid, that side is granted. If both are valid, the side selected by the priority pointer `ptr` is granted.
  - `req_x_ready` equals the grant bit and is asserted only in IDLE.
  - On a handshake (valid & ready):
    - latch velocity and angle into vp_velocity / vp_angle;
    - latch the side into out_player;
    - load the counter with LATENCY;
    - go to WAIT.
- **WAIT**
  - The counter decrements every cycle.
  - On the edge where the counter equals 1:
    - out_vx <= vp_result[31:16];
    - out_vy <= vp_result[15:0], mirrored per Configuration;
    - out_valid <= 1;
    - go to HOLD.
- **HOLD**
  - Outputs are held.
  - On an edge with out_ready = 1: out_valid <= 0, ptr <= the side not just served, go to IDLE.
- vp_velocity and vp_angle change only on request acceptance. They stay stable through WAIT and HOLD.
- Counter width: 4 bits.
- Reset:
  - all outputs 0;
  - state IDLE;
  - ptr = A;
  - counter 0.
- Reset asserted mid-transaction aborts it. No out_valid pulse occurs and the captured result is discarded.
- A request deasserted before it is granted is simply not served. No state is kept.
- Requests arriving during WAIT or HOLD see ready = 0 and must be held by the requester.

## Timing
- Acceptance edge T: vp_* are valid from T.
- out_valid rises at edge T+LATENCY. vp_* inputs have been stable for exactly LATENCY cycles when vp_result is sampled.
- out_ready may already be high when out_valid rises. The transfer then completes at T+LATENCY+1.
- The next acceptance is possible at the edge after returning to IDLE.
- Minimum spacing between acceptances: LATENCY+2 cycles.
- req_x_ready is a combinational function of the registered state, registered ptr and the current req_x_valid inputs.
- There is no combinational path from out_ready to any output.

## Configuration
- `VP_SCHED_MIRROR_EN` defined:
  - For results where out_player = 1, out_vy has bit 15 (the sign bit) inverted, because player B hits toward the opposite side.
  - Exception: a zero-magnitude vy (bits [14:0] = 0) is output as 16'h0000 and is never converted to negative zero.
  - Player A results pass through unchanged.
- Undefined: out_vy = vp_result[15:0] for both players.
- vx is never modified.

## Test plan
- **Single A request.** req_a_velocity=16'h00F0, angle=0, LATENCY=4, model result 32'h0000_00F0.
  - req_a_ready is high in the request cycle.
  - out_valid rises at T+4 with out_vx=0, out_vy=16'h00F0, out_player=0.
- **Simultaneous A and B after reset.**
  - A is served first.
  - B is held with ready=0 and is then served next.
  - Afterwards ptr points to A again.
- **Continuous requests from both players.** Grants strictly alternate A, B, A, B. Each acceptance is LATENCY+2 cycles apart when out_ready is tied high.
- **Backpressure.** out_ready is held low for 10 cycles.
  - out_valid, out_vx and out_vy stay constant.
  - No new request is accepted.
  - Both req_x_ready stay 0.
- **Reset during WAIT.** rst is pulsed 2 cycles after acceptance.
  - All outputs return to 0.
  - No out_valid pulse occurs.
  - The next request is served normally with ptr = A.
- **With VP_SCHED_MIRROR_EN defined, player B.**
  - vp_result vy=16'h00F0 gives out_vy=16'h80F0.
  - vy=16'h0000 gives out_vy=16'h0000.
  - Player A with vy=16'h00F0 gives out_vy=16'h00F0.

Source files
------------

// File: rtl/velocity_prcs_sched.sv
// Arbitrates player A/B paddle-hit requests onto the shared velocity_prcs datapath and returns the result over valid/ready.
// Define VP_SCHED_MIRROR_EN to invert the vy sign for player B results.
module velocity_prcs_sched #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a_valid,
    output logic        req_a_ready,
    input  logic [15:0] req_a_velocity,
    input  logic [15:0] req_a_angle,
    input  logic        req_b_valid,
    output logic        req_b_ready,
    input  logic [15:0] req_b_velocity,
    input  logic [15:0] req_b_angle,
    output logic [15:0] vp_velocity,
    output logic [15:0] vp_angle,
    input  logic [31:0] vp_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_vx,
    output logic [15:0] out_vy,
    output logic        out_player,
    output logic        busy
);

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    logic        ptr;
    logic [3:0]  cnt;
    logic        grant_a;
    logic        grant_b;
    logic [15:0] vy_next;

    // ptr only breaks ties; a lone request is always granted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (req_a_valid && (!req_b_valid || !ptr))
                grant_a = 1'b1;
            else if (req_b_valid)
                grant_b = 1'b1;
        end
    end

    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;
    assign busy        = (state != IDLE);

    always_comb begin
        vy_next = vp_result[15:0];
`ifdef VP_SCHED_MIRROR_EN
        // Player B plays toward the opposite side; zero magnitude stays +0.
        if (out_player) begin
            if (vp_result[14:0] == 15'd0)
                vy_next = '0;
            else
                vy_next = {~vp_result[15], vp_result[14:0]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            cnt         <= '0;
            vp_velocity <= '0;
            vp_angle    <= '0;
            out_valid   <= 1'b0;
            out_vx      <= '0;
            out_vy      <= '0;
            out_player  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        vp_velocity <= grant_b ? req_b_velocity : req_a_velocity;
                        vp_angle    <= grant_b ? req_b_angle    : req_a_angle;
                        out_player  <= grant_b;
                        cnt         <= LAT4;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        out_vx    <= vp_result[31:16];
                        out_vy    <= vy_next;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ptr       <= ~out_player;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
